// File: rtl/axi_sram_responder.sv
// axi_sram_responder
//
// AXI3 responder that terminates an AXI master with a word-organised SRAM
// model. One read burst and one write burst may be in flight at a time, on
// independent channels. Byte strobes are applied as given (no lane rotation).
// Beats outside the array, with size > 4 bytes or with WRAP/reserved bursts
// answer SLVERR; such write beats are dropped.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ar* / arready               read address channel
//   aw* / awready               write address channel
//   rid rdata rresp rlast rvalid / rready   read data channel
//   wid wdata wstrb wlast wvalid / wready   write data channel
//   bid bresp bvalid / bready               write response channel
//   lock, cache, prot and wid are accepted and ignored.

module axi_sram_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
  parameter int          RD_DELAY  = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  // AR channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // AW channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // R channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // W channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // B channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES   = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  RD_CNT_INIT = (RD_DELAY > 0) ? 4'(RD_DELAY - 1) : 4'd0;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

  // A beat is serviceable only inside the array, at most word-sized, FIXED/INCR.
  function automatic logic beat_ok(input logic [31:0] addr, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    beat_ok = (addr >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES) && (size <= 3'd2) &&
              ((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    word_idx = IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // FIXED holds the address; INCR steps by the transfer size with 32-bit wrap.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    if (burst == BURST_INCR) begin
      next_addr = addr + (32'd1 << size);
    end else begin
      next_addr = addr;
    end
  endfunction

  logic [31:0] mem_r [0:MEM_WORDS-1];

  wire logic unused_s = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // ------------------------------------------------------------------ read
  r_state_t    r_state_r, r_next_s;
  logic [3:0]  r_id_r, r_len_r, r_beat_r, r_cnt_r;
  logic [31:0] r_addr_r;           // address of the next beat to be loaded
  logic [2:0]  r_size_r;
  logic [1:0]  r_burst_r;
  logic        ld_en_s, ld_ok_s;
  logic [31:0] ld_addr_s, ld_data_s;
  logic [2:0]  ld_size_s;
  logic [1:0]  ld_burst_s;
  logic [3:0]  ld_len_s, ld_beat_s;

  // Read next-state and beat-load selection.
  always_comb begin
    r_next_s   = r_state_r;
    ld_en_s    = 1'b0;
    ld_addr_s  = r_addr_r;
    ld_size_s  = r_size_r;
    ld_burst_s = r_burst_r;
    ld_len_s   = r_len_r;
    ld_beat_s  = r_beat_r + 4'd1;
    case (r_state_r)
      R_IDLE: begin
        if (arvalid) begin
          if (RD_DELAY == 0) begin
            // zero delay: first beat is loaded on the AR handshake edge
            r_next_s   = R_DATA;
            ld_en_s    = 1'b1;
            ld_addr_s  = araddr;
            ld_size_s  = arsize;
            ld_burst_s = arburst;
            ld_len_s   = arlen;
            ld_beat_s  = 4'd0;
          end else begin
            r_next_s = R_WAIT;
          end
        end else begin
          r_next_s = R_IDLE;
        end
      end
      R_WAIT: begin
        if (r_cnt_r == 4'd0) begin
          r_next_s  = R_DATA;
          ld_en_s   = 1'b1;
          ld_beat_s = 4'd0;
        end else begin
          r_next_s = R_WAIT;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast) begin
            r_next_s = R_IDLE;
          end else begin
            ld_en_s = 1'b1;
          end
        end else begin
          r_next_s = R_DATA;
        end
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Memory lookup for the beat being loaded; bad beats read as zero.
  always_comb begin
    ld_ok_s = beat_ok(ld_addr_s, ld_size_s, ld_burst_s);
    if (ld_ok_s) begin
      ld_data_s = mem_r[word_idx(ld_addr_s)];
    end else begin
      ld_data_s = 32'd0;
    end
  end

  // Read channel registers: state, captured AR fields and the R beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_r <= R_IDLE;
      r_id_r    <= 4'd0;
      r_len_r   <= 4'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'd0;
      r_addr_r  <= 32'd0;
      r_cnt_r   <= 4'd0;
      r_beat_r  <= 4'd0;
      rdata     <= 32'd0;
      rresp     <= 2'd0;
      rlast     <= 1'b0;
    end else begin
      r_state_r <= r_next_s;
      if ((r_state_r == R_IDLE) && arvalid) begin
        r_id_r    <= arid;
        r_len_r   <= arlen;
        r_size_r  <= arsize;
        r_burst_r <= arburst;
        r_cnt_r   <= RD_CNT_INIT;
      end
      if (ld_en_s) begin
        r_addr_r <= next_addr(ld_addr_s, ld_size_s, ld_burst_s);
        r_beat_r <= ld_beat_s;
        rdata    <= ld_data_s;
        rresp    <= ld_ok_s ? RESP_OKAY : RESP_SLVERR;
        rlast    <= (ld_beat_s == ld_len_s);
      end else if ((r_state_r == R_IDLE) && arvalid) begin
        r_addr_r <= araddr;
      end else if ((r_state_r == R_DATA) && rready) begin
        rlast <= 1'b0;
      end
      if ((r_state_r == R_WAIT) && (r_cnt_r != 4'd0)) begin
        r_cnt_r <= r_cnt_r - 4'd1;
      end
    end
  end

  assign arready = (r_state_r == R_IDLE);
  assign rvalid  = (r_state_r == R_DATA);
  assign rid     = r_id_r;

  // ----------------------------------------------------------------- write
  w_state_t    w_state_r, w_next_s;
  logic [3:0]  w_id_r, w_len_r, w_beat_r;
  logic [31:0] w_addr_r;
  logic [2:0]  w_size_r;
  logic [1:0]  w_burst_r;
  logic        w_over_r;            // all awlen+1 beats seen, wlast still pending
  logic        w_err_r;
  logic        w_hs_s, w_ok_s, w_mis_s, w_err_s, mem_we_s;

  // Write beat qualification and accumulated error.
  always_comb begin
    w_hs_s   = (w_state_r == W_DATA) && wvalid;
    w_ok_s   = beat_ok(w_addr_r, w_size_r, w_burst_r) && !w_over_r;
    // wlast must land exactly on beat awlen+1
    w_mis_s  = wlast && !((w_beat_r == w_len_r) && !w_over_r);
    w_err_s  = w_err_r || !w_ok_s || w_mis_s;
    mem_we_s = w_hs_s && w_ok_s;
  end

  // Write next-state.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (awvalid) begin
          w_next_s = W_DATA;
        end else begin
          w_next_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (wvalid && wlast) begin
          w_next_s = W_RESP;
        end else begin
          w_next_s = W_DATA;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_next_s = W_IDLE;
        end else begin
          w_next_s = W_RESP;
        end
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write channel registers: state, captured AW fields, beat tracking, bresp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_r <= W_IDLE;
      w_id_r    <= 4'd0;
      w_len_r   <= 4'd0;
      w_size_r  <= 3'd0;
      w_burst_r <= 2'd0;
      w_addr_r  <= 32'd0;
      w_beat_r  <= 4'd0;
      w_over_r  <= 1'b0;
      w_err_r   <= 1'b0;
      bresp     <= 2'd0;
    end else begin
      w_state_r <= w_next_s;
      if ((w_state_r == W_IDLE) && awvalid) begin
        w_id_r    <= awid;
        w_len_r   <= awlen;
        w_size_r  <= awsize;
        w_burst_r <= awburst;
        w_addr_r  <= awaddr;
        w_beat_r  <= 4'd0;
        w_over_r  <= 1'b0;
        w_err_r   <= 1'b0;
      end else if (w_hs_s) begin
        w_err_r  <= w_err_s;
        w_addr_r <= next_addr(w_addr_r, w_size_r, w_burst_r);
        if (w_beat_r == w_len_r) begin
          w_over_r <= 1'b1;
        end else begin
          w_beat_r <= w_beat_r + 4'd1;
        end
        if (wlast) begin
          bresp <= w_err_s ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-strobed store; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem_r[word_idx(w_addr_r)][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign awready = (w_state_r == W_IDLE);
  assign wready  = (w_state_r == W_DATA);
  assign bvalid  = (w_state_r == W_RESP);
  assign bid     = w_id_r;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder (defaults: 4096 words at 0x1c00_0000,
// RD_DELAY=2). Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point, well away from the next edge.

module tb_axi_sram_responder;

  logic        clk, rst_n;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, awvalid, wlast, wvalid, rready, bready;
  logic        arready, awready, rlast, rvalid, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  axi_sram_responder dut (
    .clk(clk), .rst_n(rst_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int timeouts = 0;

  logic [31:0] rd_data [0:16];
  logic [1:0]  rd_resp [0:16];
  logic        rd_last [0:16];
  logic [3:0]  rd_id;
  int          rd_n, rd_lat;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int nbeats,
                           input logic [31:0] d0, input logic [3:0] strb, input logic [3:0] id);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick; n++; end
    if (n >= 50) timeouts++;
    tick;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = d0 + 32'(i); wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin tick; n++; end
      if (n >= 50) timeouts++;
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin tick; n++; end
    if (n >= 50) timeouts++;
    wr_resp = bresp; wr_bid = bid;
    tick;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] id, input logic toggle);
    int n, cyc;
    logic phase, stalled, done, st_last;
    logic [31:0] st_data;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick; n++; end
    if (n >= 50) timeouts++;
    tick;
    arvalid = 1'b0;
    rd_n = 0; rd_lat = -1; phase = 1'b1; stalled = 1'b0; done = 1'b0; cyc = 0;
    st_data = 32'd0; st_last = 1'b0;
    while (!done && cyc < 200) begin
      if (rvalid) begin
        if (rd_lat < 0) rd_lat = cyc;
        rready = !toggle || phase;
        phase = !phase;
        if (rready) begin
          if (stalled) begin
            chk("stall_data", rdata, st_data);
            chk("stall_last", {31'd0, rlast}, {31'd0, st_last});
            stalled = 1'b0;
          end
          rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_id = rid;
          rd_n++;
          if (rlast || rd_n == 16) done = 1'b1;
        end else begin
          st_data = rdata; st_last = rlast; stalled = 1'b1;
        end
      end else begin
        rready = 1'b0;
      end
      tick;
      cyc++;
    end
    rready = 1'b0;
    if (!done) timeouts++;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arsize = 3'd0; arburst = 2'd0;
    arlock = 2'd0; arcache = 4'd0; arprot = 3'd0; arvalid = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awlen = 4'd0; awsize = 3'd0; awburst = 2'd0;
    awlock = 2'd0; awcache = 4'd0; awprot = 3'd0; awvalid = 1'b0;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    #22;
    // reset state
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rlast",   {31'd0, rlast},   32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_rid",     {28'd0, rid},     32'd0);
    chk("rst_bid",     {28'd0, bid},     32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_rresp",   {30'd0, rresp},   32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    rst_n = 1'b1;
    tick;

    // single write then read
    axi_write(32'h1c00_0010, 4'd0, 2'b01, 1, 32'hdead_beef, 4'hf, 4'd5);
    chk("t1_bresp", {30'd0, wr_resp}, 32'd0);
    chk("t1_bid",   {28'd0, wr_bid},  32'd5);
    axi_read(32'h1c00_0010, 4'd0, 2'b01, 4'd3, 1'b0);
    chk("t1_nbeats", 32'(rd_n), 32'd1);
    chk("t1_rdata",  rd_data[0], 32'hdead_beef);
    chk("t1_rresp",  {30'd0, rd_resp[0]}, 32'd0);
    chk("t1_rlast",  {31'd0, rd_last[0]}, 32'd1);
    chk("t1_rid",    {28'd0, rd_id}, 32'd3);
    chk("t1_latency", 32'(rd_lat), 32'd2);

    // strobes
    axi_write(32'h1c00_0020, 4'd0, 2'b01, 1, 32'h1122_3344, 4'hf, 4'd1);
    axi_write(32'h1c00_0020, 4'd0, 2'b01, 1, 32'haabb_ccdd, 4'b0101, 4'd1);
    chk("t2_bresp", {30'd0, wr_resp}, 32'd0);
    axi_read(32'h1c00_0020, 4'd0, 2'b01, 4'd2, 1'b0);
    chk("t2_rdata", rd_data[0], 32'h11bb_33dd);

    // INCR burst with backpressure
    axi_write(32'h1c00_0000, 4'd3, 2'b01, 4, 32'ha000_0000, 4'hf, 4'd7);
    chk("t3_wr_bresp", {30'd0, wr_resp}, 32'd0);
    axi_read(32'h1c00_0000, 4'd3, 2'b01, 4'd9, 1'b1);
    chk("t3_nbeats", 32'(rd_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_rdata", rd_data[i], 32'ha000_0000 + 32'(i));
      chk("t3_rresp", {30'd0, rd_resp[i]}, 32'd0);
      chk("t3_rlast", {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
    end

    // out of range at the top of the array
    axi_write(32'h1c00_3ffc, 4'd1, 2'b01, 2, 32'h5566_0000, 4'hf, 4'd4);
    chk("t4_wr_bresp", {30'd0, wr_resp}, 32'd2);
    axi_read(32'h1c00_3ffc, 4'd1, 2'b01, 4'd4, 1'b0);
    chk("t4_nbeats",  32'(rd_n), 32'd2);
    chk("t4_rdata0",  rd_data[0], 32'h5566_0000);
    chk("t4_rresp0",  {30'd0, rd_resp[0]}, 32'd0);
    chk("t4_rdata1",  rd_data[1], 32'd0);
    chk("t4_rresp1",  {30'd0, rd_resp[1]}, 32'd2);
    chk("t4_rlast1",  {31'd0, rd_last[1]}, 32'd1);
    axi_read(32'h1c00_0000, 4'd0, 2'b01, 4'd4, 1'b0);
    chk("t4_word0_intact", rd_data[0], 32'ha000_0000);

    // early wlast: awlen=1 but wlast on beat 1
    axi_write(32'h1c00_0040, 4'd1, 2'b01, 2, 32'h0100_0000, 4'hf, 4'd2);
    axi_write(32'h1c00_0040, 4'd1, 2'b01, 1, 32'h7700_0000, 4'hf, 4'd2);
    chk("t5_early_bresp", {30'd0, wr_resp}, 32'd2);
    axi_read(32'h1c00_0040, 4'd1, 2'b01, 4'd2, 1'b0);
    chk("t5_early_w0", rd_data[0], 32'h7700_0000);
    chk("t5_early_w1", rd_data[1], 32'h0100_0001);
    // WRAP: rejected, memory untouched
    axi_write(32'h1c00_0040, 4'd1, 2'b10, 2, 32'h9900_0000, 4'hf, 4'd2);
    chk("t5_wrap_bresp", {30'd0, wr_resp}, 32'd2);
    axi_read(32'h1c00_0040, 4'd1, 2'b01, 4'd2, 1'b0);
    chk("t5_wrap_w0", rd_data[0], 32'h7700_0000);
    chk("t5_wrap_w1", rd_data[1], 32'h0100_0001);
    // late wlast: awlen=0 with three beats, extras dropped
    axi_write(32'h1c00_0048, 4'd1, 2'b01, 2, 32'h0200_0000, 4'hf, 4'd2);
    axi_write(32'h1c00_0048, 4'd0, 2'b01, 3, 32'h8800_0000, 4'hf, 4'd2);
    chk("t5_late_bresp", {30'd0, wr_resp}, 32'd2);
    axi_read(32'h1c00_0048, 4'd1, 2'b01, 4'd2, 1'b0);
    chk("t5_late_w0", rd_data[0], 32'h8800_0000);
    chk("t5_late_w1", rd_data[1], 32'h0200_0001);
    // FIXED read repeats the same word
    axi_read(32'h1c00_0040, 4'd1, 2'b00, 4'd6, 1'b0);
    chk("t5_fixed_b1", rd_data[1], 32'h7700_0000);
    chk("t5_fixed_resp", {30'd0, rd_resp[1]}, 32'd0);

    // read/write collision on the read's load edge
    axi_write(32'h1c00_0060, 4'd0, 2'b01, 1, 32'h0c0c_0c0c, 4'hf, 4'd3);
    arid = 4'd8; araddr = 32'h1c00_0060; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    awid = 4'd9; awaddr = 32'h1c00_0060; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01;
    arvalid = 1'b1; awvalid = 1'b1;
    chk("t6_both_ready", {30'd0, arready, awready}, 32'd3);
    tick;                                   // AR and AW handshake
    arvalid = 1'b0; awvalid = 1'b0;
    tick;
    wdata = 32'hf0f0_f0f0; wstrb = 4'hf; wlast = 1'b1; wvalid = 1'b1;
    chk("t6_wready", {31'd0, wready}, 32'd1);
    tick;                                   // W commit and R load together
    wvalid = 1'b0; wlast = 1'b0;
    chk("t6_rvalid", {31'd0, rvalid}, 32'd1);
    chk("t6_old_data", rdata, 32'h0c0c_0c0c);
    chk("t6_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t6_bid", {28'd0, bid}, 32'd9);
    rready = 1'b1; bready = 1'b1;
    tick;
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h1c00_0060, 4'd0, 2'b01, 4'd8, 1'b0);
    chk("t6_new_data", rd_data[0], 32'hf0f0_f0f0);

    // reset mid-burst on both channels
    arid = 4'd1; araddr = 32'h1c00_0000; arlen = 4'd3; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd1; awaddr = 32'h1c00_0070; awlen = 4'd1; awburst = 2'b01; awvalid = 1'b1;
    tick;
    arvalid = 1'b0; awvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin tick; n++; end
    if (n >= 50) timeouts++;
    tick;                                   // first beat accepted
    chk("t7_pre_rvalid", {31'd0, rvalid}, 32'd1);
    chk("t7_pre_wready", {31'd0, wready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rvalid",  {31'd0, rvalid},  32'd0);
    chk("t7_rlast",   {31'd0, rlast},   32'd0);
    chk("t7_arready", {31'd0, arready}, 32'd1);
    chk("t7_awready", {31'd0, awready}, 32'd1);
    chk("t7_wready",  {31'd0, wready},  32'd0);
    chk("t7_rdata",   rdata, 32'd0);
    #2;
    rst_n = 1'b1;
    rready = 1'b0;
    tick;
    chk("t7_post_arready", {31'd0, arready}, 32'd1);
    chk("t7_post_rvalid",  {31'd0, rvalid},  32'd0);
    axi_read(32'h1c00_0004, 4'd0, 2'b01, 4'd2, 1'b0);
    chk("t7_persist", rd_data[0], 32'ha000_0001);

    chk("timeouts", 32'(timeouts), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
